// File: rtl/miner_uart_pkg.sv
// Shared encodings and frame constants
// for the golden nonce UART reporter.
package miner_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int START_BITS      = 1;
  localparam int DATA_BITS       = 8;
  localparam int STOP_BITS       = 1;
  localparam int BYTES_PER_NONCE = 4;
  localparam int BAUD_DIV_DEF    = 434;

endpackage

// File: rtl/golden_nonce_tx_if.sv
// Byte-level handshake between the nonce
// sequencer and the UART byte shifter.
interface golden_nonce_tx_if;
  import miner_uart_pkg::*;

  tx_state_t   phase;
  logic        start;
  logic [7:0]  data;
  logic        done;
  logic        last;

  modport master (
    output phase, start, data,
    input  done, last
  );

  modport slave (
    input  phase, start, data,
    output done, last
  );

endinterface

// File: rtl/golden_nonce_tx_byte.sv
// UART byte shifter with baud counter;
// TxD is registered from the next phase.
module uart_tx_byte
  import miner_uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  golden_nonce_tx_if.slave tx_if,
  output logic txd_o
);

  tx_state_t   ph_q;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        txd_q, txd_d;
  logic        wrap, enter;
  logic [2:0]  lim;

  assign wrap  = baud_q == 16'(BAUD_DIV - 1);
  assign enter = tx_if.phase != ph_q;

  always_comb begin
    unique case (ph_q)
      START:   lim = 3'(START_BITS - 1);
      DATA:    lim = 3'(DATA_BITS - 1);
      default: lim = 3'(STOP_BITS - 1);
    endcase
  end

  assign tx_if.done = wrap;
  assign tx_if.last = bit_q == lim;

  always_comb begin
    baud_d = wrap ? '0 : baud_q + 16'd1;
    bit_d  = bit_q;
    sh_d   = sh_q;
    // Every phase change restarts bit timing.
    if (enter) begin
      baud_d = '0;
      bit_d  = '0;
    end else if (wrap) begin
      bit_d = bit_q + 3'd1;
      if (ph_q == DATA)
        sh_d = {1'b0, sh_q[7:1]};
    end
    if (tx_if.start)
      sh_d = tx_if.data;
    unique case (1'b1)
      tx_if.phase == START: txd_d = 1'b0;
      tx_if.phase == DATA:  txd_d = sh_d[0];
      default:              txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q   <= IDLE;
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      txd_q  <= 1'b1;
    end else begin
      ph_q   <= tx_if.phase;
      baud_q <= baud_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      txd_q  <= txd_d;
    end
  end

  assign txd_o = txd_q;

endmodule

// File: rtl/golden_nonce_tx.sv
// Queues golden nonces and sends each one
// over UART as four bytes, MSB first.
module golden_nonce_tx
  import miner_uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] golden_nonce,
  input  logic        golden_nonce_valid,
  output logic        TxD,
  output logic        busy,
  output logic        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full, push, pop;

  tx_state_t     state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_q, word_d;

  golden_nonce_tx_if tx_if ();

  assign full = cnt_q == CW'(FIFO_DEPTH);
  assign pop  = state_q == LOAD;
  // A full FIFO still takes a nonce
  // when LOAD frees a slot that cycle.
  assign push = golden_nonce_valid &&
                (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q ||
               (golden_nonce_valid &&
                full && !pop);
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    unique case (state_q)
      IDLE:
        if (cnt_q != '0)
          state_d = LOAD;
      LOAD: begin
        state_d    = START;
        word_d     = mem_q[rd_ptr_q];
        byte_idx_d = '0;
      end
      START:
        if (tx_if.done && tx_if.last)
          state_d = DATA;
      DATA:
        if (tx_if.done && tx_if.last)
          state_d = STOP;
      STOP:
        if (tx_if.done && tx_if.last) begin
          if (byte_idx_q !=
              2'(BYTES_PER_NONCE - 1)) begin
            byte_idx_d = byte_idx_q + 2'd1;
            word_d     = {word_q[23:0], 8'h00};
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      default: state_d = IDLE;
    endcase
  end

  assign tx_if.phase = state_d;
  assign tx_if.start = (state_d == START) &&
                       (state_q != START);
  assign tx_if.data  = word_d[31:24];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      state_q    <= IDLE;
      byte_idx_q <= '0;
      word_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push)
      mem_q[wr_ptr_q] <= golden_nonce;
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk_i (clk),
    .rst_i (reset),
    .tx_if (tx_if),
    .txd_o (TxD)
  );

  assign busy       = (state_q != IDLE) ||
                      (cnt_q != '0);
  assign overflow   = ovf_q;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_golden_nonce_tx.sv
// Scoreboard bench: a UART decoder turns
// TxD back into nonces for comparison.
module tb_golden_nonce_tx;

  localparam int BD = 4;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] golden_nonce = '0;
  logic        golden_nonce_valid = 1'b0;
  logic        TxD;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] expq[$];
  logic [31:0] rxq[$];
  int          startq[$];
  int          endq[$];
  logic        endbusyq[$];

  int          fall_cnt = 0;
  int          frm_err = 0;
  int          mcnt = 0;
  int          mnb = 0;
  int          mst = 0;
  bit          mact = 1'b0;
  logic [7:0]  msh = '0;
  logic [31:0] mword = '0;

  golden_nonce_tx #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .golden_nonce       (golden_nonce),
    .golden_nonce_valid (golden_nonce_valid),
    .TxD                (TxD),
    .busy               (busy),
    .overflow           (overflow),
    .fifo_count         (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      mact = 1'b0;
      mcnt = 0;
      mnb  = 0;
    end else begin
      if (!mact && TxD === 1'b0) begin
        mact = 1'b1;
        mcnt = 0;
        fall_cnt++;
        if (mnb == 0) mst = cyc;
      end
      if (mact) begin
        if (mcnt % BD == BD / 2) begin
          if (mcnt / BD == 0) begin
            if (TxD !== 1'b0) frm_err++;
          end else if (mcnt / BD == 9) begin
            if (TxD !== 1'b1) frm_err++;
          end else begin
            msh[mcnt / BD - 1] = TxD;
          end
        end
        if (mcnt == 10 * BD - 1) begin
          mact  = 1'b0;
          mword = {mword[23:0], msh};
          mnb++;
          if (mnb == 4) begin
            rxq.push_back(mword);
            startq.push_back(mst);
            endq.push_back(cyc);
            endbusyq.push_back(busy);
            mnb = 0;
          end
        end
        mcnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] n);
    golden_nonce       = n;
    golden_nonce_valid = 1'b1;
    tick();
    golden_nonce_valid = 1'b0;
  endtask

  task automatic clear_sb();
    expq.delete();
    rxq.delete();
    startq.delete();
    endq.delete();
    endbusyq.delete();
  endtask

  task automatic wait_rx(input int n,
                         input int lim,
                         output bit ok);
    for (int i = 0; i < lim && rxq.size() < n; i++)
      tick();
    ok = (rxq.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    golden_nonce_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    total++;
    if (TxD !== 1'b1) begin
      bad++;
      $display("FAIL rst_txd got=%b want=1", TxD);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy got=%b want=0", busy);
    end
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL rst_ovf got=%b want=0", overflow);
    end
    total++;
    if (fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL rst_cnt got=%0d want=0", fifo_count);
    end
  endtask

  task automatic test_single();
    int sc;
    bit ok;
    logic [31:0] e, g;
    clear_sb();
    sc = cyc;
    expq.push_back(32'h1afda099);
    strobe(32'h1afda099);
    total++;
    if (fifo_count !== 3'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL one_queued got=%0d/%b want=1/1",
               fifo_count, busy);
    end
    wait_rx(1, 400, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL one_wait got=%0d want=1", rxq.size());
    end
    if (ok) begin
      e = expq.pop_front();
      g = rxq.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL one_nonce got=%h want=%h", g, e);
      end
      total++;
      if (startq[0] - sc != 3) begin
        bad++;
        $display("FAIL one_latency got=%0d want=3",
                 startq[0] - sc);
      end
      total++;
      if (endq[0] - startq[0] + 1 != 40 * BD) begin
        bad++;
        $display("FAIL one_len got=%0d want=%0d",
                 endq[0] - startq[0] + 1, 40 * BD);
      end
      total++;
      if (endbusyq[0] !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL one_busy got=%b%b want=10",
                 endbusyq[0], busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] e, g;
    clear_sb();
    expq.push_back(32'h30d9db77);
    expq.push_back(32'h00000001);
    strobe(32'h30d9db77);
    strobe(32'h00000001);
    wait_rx(2, 800, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_wait got=%0d want=2", rxq.size());
    end
    if (ok) begin
      total++;
      if (startq[1] - endq[0] - 1 != 2) begin
        bad++;
        $display("FAIL b2b_gap got=%0d want=2",
                 startq[1] - endq[0] - 1);
      end
      total++;
      if (endq[1] - startq[1] + 1 != 40 * BD) begin
        bad++;
        $display("FAIL b2b_len got=%0d want=%0d",
                 endq[1] - startq[1] + 1, 40 * BD);
      end
      for (int i = 0; i < 2; i++) begin
        e = expq.pop_front();
        g = rxq.pop_front();
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL b2b_nonce%0d got=%h want=%h",
                   i, g, e);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [31:0] n, e, g;
    clear_sb();
    n = $urandom;
    expq.push_back(n);
    strobe(n);
    repeat (10) tick();
    for (int i = 1; i <= 5; i++) begin
      n = $urandom;
      if (i <= 4) expq.push_back(n);
      strobe(n);
    end
    total++;
    if (fifo_count !== 3'd4) begin
      bad++;
      $display("FAIL ovf_peak got=%0d want=4", fifo_count);
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flag got=%b want=1", overflow);
    end
    wait_rx(5, 1500, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ovf_wait got=%0d want=5", rxq.size());
    end
    for (int i = 0; i < 5 && ok; i++) begin
      e = expq.pop_front();
      g = rxq.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL ovf_nonce%0d got=%h want=%h",
                 i, g, e);
      end
    end
    repeat (200) tick();
    total++;
    if (rxq.size() != 0 || fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL ovf_extra got=%0d/%0d want=0/0",
               rxq.size(), fifo_count);
    end
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b want=1", overflow);
    end
  endtask

  task automatic test_full_pop();
    int sc;
    bit ok;
    logic [31:0] n, e, g;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL fp_ovf_clr got=%b want=0", overflow);
    end
    clear_sb();
    sc = cyc;
    n = $urandom;
    expq.push_back(n);
    strobe(n);
    repeat (5) tick();
    for (int i = 0; i < 4; i++) begin
      n = $urandom;
      expq.push_back(n);
      strobe(n);
    end
    while (cyc < sc + 164) tick();
    total++;
    if (fifo_count !== 3'd4) begin
      bad++;
      $display("FAIL fp_full got=%0d want=4", fifo_count);
    end
    n = $urandom;
    expq.push_back(n);
    strobe(n);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL fp_ovf got=%b want=0", overflow);
    end
    total++;
    if (fifo_count !== 3'd4) begin
      bad++;
      $display("FAIL fp_cnt got=%0d want=4", fifo_count);
    end
    wait_rx(6, 1500, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL fp_wait got=%0d want=6", rxq.size());
    end
    for (int i = 0; i < 6 && ok; i++) begin
      e = expq.pop_front();
      g = rxq.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL fp_nonce%0d got=%h want=%h",
                 i, g, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int sc, f0;
    bit ok;
    logic [31:0] e, g;
    clear_sb();
    sc = cyc;
    strobe($urandom);
    strobe($urandom);
    while (cyc < sc + 53) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (TxD !== 1'b1) begin
      bad++;
      $display("FAIL rm_txd got=%b want=1", TxD);
    end
    total++;
    if (fifo_count !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rm_cnt got=%0d/%b want=0/0",
               fifo_count, busy);
    end
    f0 = fall_cnt;
    repeat (300) tick();
    total++;
    if (fall_cnt != f0 || rxq.size() != 0) begin
      bad++;
      $display("FAIL rm_quiet got=%0d/%0d want=0/0",
               fall_cnt - f0, rxq.size());
    end
    expq.push_back(32'hc0ffee42);
    strobe(32'hc0ffee42);
    wait_rx(1, 400, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rm_wait got=%0d want=1", rxq.size());
    end
    if (ok) begin
      e = expq.pop_front();
      g = rxq.pop_front();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL rm_nonce got=%h want=%h", g, e);
      end
    end
  endtask

  task automatic test_reset_strobe();
    int f0;
    f0 = fall_cnt;
    reset = 1'b1;
    golden_nonce = 32'h5a5a5a5a;
    golden_nonce_valid = 1'b1;
    tick();
    reset = 1'b0;
    golden_nonce_valid = 1'b0;
    total++;
    if (fifo_count !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rs_cnt got=%0d/%b want=0/0",
               fifo_count, busy);
    end
    repeat (30) tick();
    total++;
    if (fall_cnt != f0 || TxD !== 1'b1) begin
      bad++;
      $display("FAIL rs_quiet got=%0d/%b want=0/1",
               fall_cnt - f0, TxD);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_reset_strobe();
    total++;
    if (frm_err != 0) begin
      bad++;
      $display("FAIL framing got=%0d want=0", frm_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
